// File: rtl/sprite_pkg.sv
// Shared shape codes and 3x3 shape masks for the sprite raster engine.
// Mask bit 8 is the top-left cell, row-major, so bit 0 is bottom-right.
package sprite_pkg;

   localparam int SHAPE_W = 3;

   typedef enum logic [SHAPE_W-1:0] {
      SHAPE_UP    = 3'd0,
      SHAPE_RIGHT = 3'd1,
      SHAPE_DOWN  = 3'd2,
      SHAPE_LEFT  = 3'd3,
      SHAPE_POINT = 3'd4,
      SHAPE_BLOCK = 3'd5
   } shape_e;

   localparam logic [8:0] MASK_UP    = 9'b010_111_101;
   localparam logic [8:0] MASK_RIGHT = 9'b110_011_110;
   localparam logic [8:0] MASK_DOWN  = 9'b101_111_010;
   localparam logic [8:0] MASK_LEFT  = 9'b011_110_011;
   localparam logic [8:0] MASK_POINT = 9'b000_010_000;
   localparam logic [8:0] MASK_BLOCK = 9'b111_111_111;

   // Unused codes 6 and 7 fall back to a single point.
   function automatic logic [8:0] shape_mask(input logic [SHAPE_W-1:0] code);
      case (code)
         SHAPE_UP:    return MASK_UP;
         SHAPE_RIGHT: return MASK_RIGHT;
         SHAPE_DOWN:  return MASK_DOWN;
         SHAPE_LEFT:  return MASK_LEFT;
         SHAPE_BLOCK: return MASK_BLOCK;
         default:     return MASK_POINT;
      endcase
   endfunction

endpackage

// File: rtl/sprite_hit.sv
// Combinational cover test of one pixel against one 3x3 sprite.
// Offsets are formed one bit wider than the coordinates so edges clip instead of wrapping.
module sprite_hit
   import sprite_pkg::*;
#(
   parameter int X_W = 8,
   parameter int Y_W = 7
) (
   input  logic [X_W-1:0]     pix_x,
   input  logic [Y_W-1:0]     pix_y,
   input  logic [X_W-1:0]     cx,
   input  logic [Y_W-1:0]     cy,
   input  logic [SHAPE_W-1:0] shape,
   input  logic               valid,
   output logic               hit
);

   localparam logic signed [X_W:0] ONE_X = {{X_W{1'b0}}, 1'b1};
   localparam logic signed [Y_W:0] ONE_Y = {{Y_W{1'b0}}, 1'b1};

   logic signed [X_W:0] dx;
   logic signed [Y_W:0] dy;
   logic signed [X_W:0] dx_off;
   logic signed [Y_W:0] dy_off;
   logic                in_x;
   logic                in_y;
   logic [3:0]          idx;
   logic [8:0]          mask;

   assign dx     = $signed({1'b0, pix_x}) - $signed({1'b0, cx});
   assign dy     = $signed({1'b0, pix_y}) - $signed({1'b0, cy});
   // Offset by one so the 3x3 window maps to 0..2 in the low two bits.
   assign dx_off = dx + ONE_X;
   assign dy_off = dy + ONE_Y;
   assign in_x   = (dx_off[X_W:2] == '0) && (dx_off[1:0] != 2'b11);
   assign in_y   = (dy_off[Y_W:2] == '0) && (dy_off[1:0] != 2'b11);
   assign idx    = ({2'b00, dy_off[1:0]} * 4'd3) + {2'b00, dx_off[1:0]};
   assign mask   = shape_mask(shape);
   assign hit    = valid && in_x && in_y && mask[4'd8 - idx];

endmodule

// File: rtl/sprite_raster_engine.sv
// Raster scan renderer: counter, per-sprite cover stage, priority/colour stage with
// per-frame collision reporting against sprite 0. Sprite inputs are shadowed per frame.
module sprite_raster_engine
   import sprite_pkg::*;
#(
   parameter int H_RES     = 160,
   parameter int V_RES     = 120,
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int NUM_SPR   = 8,
   parameter int COLOUR_W  = 3,
   parameter int BG_COLOUR = 0
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic                          enable,
   input  logic [NUM_SPR-1:0]            spr_valid,
   input  logic [NUM_SPR*X_W-1:0]        spr_x,
   input  logic [NUM_SPR*Y_W-1:0]        spr_y,
   input  logic [NUM_SPR*SHAPE_W-1:0]    spr_shape,
   input  logic [NUM_SPR*COLOUR_W-1:0]   spr_colour,
   output logic [X_W-1:0]                x,
   output logic [Y_W-1:0]                y,
   output logic [COLOUR_W-1:0]           colour,
   output logic                          plot,
   output logic                          frame_done,
   output logic [NUM_SPR-1:0]            coll
);

   localparam logic [X_W-1:0]      X_LAST = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0]      Y_LAST = Y_W'(V_RES - 1);
   localparam logic [COLOUR_W-1:0] BG     = COLOUR_W'(BG_COLOUR);

   logic [X_W-1:0]                x_cnt;
   logic [Y_W-1:0]                y_cnt;
   logic                          latch;
   logic                          last_p0;

   logic [NUM_SPR-1:0]            sh_valid;
   logic [NUM_SPR*X_W-1:0]        sh_x;
   logic [NUM_SPR*Y_W-1:0]        sh_y;
   logic [NUM_SPR*SHAPE_W-1:0]    sh_shape;
   logic [NUM_SPR*COLOUR_W-1:0]   sh_colour;

   logic [NUM_SPR-1:0]            eff_valid;
   logic [NUM_SPR*X_W-1:0]        eff_x;
   logic [NUM_SPR*Y_W-1:0]        eff_y;
   logic [NUM_SPR*SHAPE_W-1:0]    eff_shape;
   logic [NUM_SPR-1:0]            cover_p0;

   logic [X_W-1:0]                x_p1;
   logic [Y_W-1:0]                y_p1;
   logic [NUM_SPR-1:0]            cover_p1;
   logic                          vld_p1;
   logic                          last_p1;

   logic [COLOUR_W-1:0]           win_colour;
   logic [NUM_SPR-1:1]            hit_p1;
   logic [NUM_SPR-1:1]            acc;
   logic [NUM_SPR-1:1]            acc_next;
   logic                          last_p2;

   // Stage 0: raster counter and frame-start shadow latch
   assign latch   = enable && (x_cnt == '0) && (y_cnt == '0);
   assign last_p0 = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (enable) begin
         if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + Y_W'(1);
         end else begin
            x_cnt <= x_cnt + X_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sh_valid  <= '0;
         sh_x      <= '0;
         sh_y      <= '0;
         sh_shape  <= '0;
         sh_colour <= '0;
      end else if (latch) begin
         sh_valid  <= spr_valid;
         sh_x      <= spr_x;
         sh_y      <= spr_y;
         sh_shape  <= spr_shape;
         sh_colour <= spr_colour;
      end
   end

   // Pixel (0,0) is evaluated on the latch cycle itself, so it must see the incoming values.
   assign eff_valid = latch ? spr_valid : sh_valid;
   assign eff_x     = latch ? spr_x     : sh_x;
   assign eff_y     = latch ? spr_y     : sh_y;
   assign eff_shape = latch ? spr_shape : sh_shape;

   for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
      sprite_hit #(.X_W(X_W), .Y_W(Y_W)) u_hit (
         .pix_x (x_cnt),
         .pix_y (y_cnt),
         .cx    (eff_x[i*X_W +: X_W]),
         .cy    (eff_y[i*Y_W +: Y_W]),
         .shape (eff_shape[i*SHAPE_W +: SHAPE_W]),
         .valid (eff_valid[i]),
         .hit   (cover_p0[i])
      );
   end

   // Stage 1: registered cover bits
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         vld_p1  <= enable;
         last_p1 <= last_p0;
      end
   end

   always_ff @(posedge clock) begin
      x_p1     <= x_cnt;
      y_p1     <= y_cnt;
      cover_p1 <= cover_p0;
   end

   always_comb begin
      win_colour = BG;
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
         if (cover_p1[i]) win_colour = sh_colour[i*COLOUR_W +: COLOUR_W];
      end
   end

   assign hit_p1   = cover_p1[NUM_SPR-1:1] & {(NUM_SPR-1){cover_p1[0]}};
   assign acc_next = acc | hit_p1;

   // Stage 2: pixel outputs, collision accumulator, end-of-frame report
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         x          <= '0;
         y          <= '0;
         colour     <= BG;
         plot       <= 1'b0;
         last_p2    <= 1'b0;
         frame_done <= 1'b0;
         acc        <= '0;
         coll       <= '0;
      end else begin
         x          <= x_p1;
         y          <= y_p1;
         colour     <= win_colour;
         plot       <= vld_p1;
         last_p2    <= vld_p1 && last_p1;
         frame_done <= last_p2;
         if (vld_p1) begin
            if (last_p1) begin
               coll <= {acc_next, |acc_next};
               acc  <= '0;
            end else begin
               acc  <= acc_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_sprite_raster_engine.sv
// Bench for sprite_raster_engine: captures each frame, compares it and the collision
// report with a plain-arithmetic model, plus directed pixel, gap and reset checks.
module tb_sprite_raster_engine;

   localparam int H   = 160;
   localparam int V   = 120;
   localparam int N   = 8;
   localparam int PIX = H * V;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          enable = 1'b0;
   logic [7:0]    spr_valid;
   logic [63:0]   spr_x;
   logic [55:0]   spr_y;
   logic [23:0]   spr_shape;
   logic [23:0]   spr_colour;
   logic [7:0]    x;
   logic [6:0]    y;
   logic [2:0]    colour;
   logic          plot;
   logic          frame_done;
   logic [7:0]    coll;

   logic          s_v[N];
   logic [7:0]    s_x[N];
   logic [6:0]    s_y[N];
   logic [2:0]    s_sh[N];
   logic [2:0]    s_c[N];
   logic          snap_v[N];
   logic [7:0]    snap_x[N];
   logic [6:0]    snap_y[N];
   logic [2:0]    snap_sh[N];
   logic [2:0]    snap_c[N];

   logic [2:0]    fb[V][H];
   logic [2:0]    fb_last[V][H];

   int            checks = 0;
   int            errors = 0;
   int            n = 0;
   int            cyc = 0;
   int            dones = 0;
   int            done_cyc[$];
   logic          done_pend = 1'b0;
   logic [7:0]    exp_coll = '0;

   sprite_raster_engine dut (
      .clock(clock), .resetn(resetn), .enable(enable),
      .spr_valid(spr_valid), .spr_x(spr_x), .spr_y(spr_y),
      .spr_shape(spr_shape), .spr_colour(spr_colour),
      .x(x), .y(y), .colour(colour), .plot(plot),
      .frame_done(frame_done), .coll(coll)
   );

   initial forever #5 clock = ~clock;

   always_comb begin
      spr_valid = '0;
      spr_x = '0;
      spr_y = '0;
      spr_shape = '0;
      spr_colour = '0;
      for (int i = 0; i < N; i++) begin
         spr_valid[i]        = s_v[i];
         spr_x[i*8 +: 8]     = s_x[i];
         spr_y[i*7 +: 7]     = s_y[i];
         spr_shape[i*3 +: 3] = s_sh[i];
         spr_colour[i*3 +: 3] = s_c[i];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Shape rows top to bottom; leftmost character of each row is dx=-1.
   function automatic bit in_mask(input logic [2:0] shp, input int dx, input int dy);
      logic [2:0] rows[3];
      case (shp)
         3'd0:    rows = '{3'b010, 3'b111, 3'b101};
         3'd1:    rows = '{3'b110, 3'b011, 3'b110};
         3'd2:    rows = '{3'b101, 3'b111, 3'b010};
         3'd3:    rows = '{3'b011, 3'b110, 3'b011};
         3'd5:    rows = '{3'b111, 3'b111, 3'b111};
         default: rows = '{3'b000, 3'b010, 3'b000};
      endcase
      return rows[dy + 1][1 - dx];
   endfunction

   function automatic bit covers(input int i, input int px, input int py);
      int dx;
      int dy;
      dx = px - int'(snap_x[i]);
      dy = py - int'(snap_y[i]);
      if (!snap_v[i]) return 1'b0;
      if (dx < -1 || dx > 1 || dy < -1 || dy > 1) return 1'b0;
      return in_mask(snap_sh[i], dx, dy);
   endfunction

   task automatic compare_frame(input int upto, output logic [7:0] c);
      c = '0;
      for (int p = 0; p < upto; p++) begin
         int px;
         int py;
         logic [2:0] e;
         bit c0;
         px = p % H;
         py = p / H;
         e  = 3'd0;
         c0 = covers(0, px, py);
         for (int i = N - 1; i >= 0; i--) if (covers(i, px, py)) e = snap_c[i];
         check("pixel", 32'(fb[py][px]), 32'(e));
         for (int i = 1; i < N; i++) begin
            if (c0 && covers(i, px, py)) begin
               c[i] = 1'b1;
               c[0] = 1'b1;
            end
         end
      end
   endtask

   task automatic step(input logic en);
      logic [7:0] c;
      enable = en;
      @(posedge clock);
      #1;
      cyc++;
      check("frame_done", 32'(frame_done), 32'(done_pend));
      if (frame_done) begin
         dones++;
         done_cyc.push_back(cyc);
      end
      done_pend = 1'b0;
      if (plot) begin
         if (n == 0) begin
            snap_v = s_v; snap_x = s_x; snap_y = s_y; snap_sh = s_sh; snap_c = s_c;
         end
         check("plot_xy", 32'({x, y}), 32'((n % H) * 128 + n / H));
         if (x < H && y < V) fb[y][x] = colour;
         if (x == H - 1 && y == V - 1) begin
            check("frame_plots", n, PIX - 1);
            compare_frame(PIX, c);
            exp_coll  = c;
            fb_last   = fb;
            done_pend = 1'b1;
            n = 0;
         end else begin
            n++;
         end
      end
      check("coll", 32'(coll), 32'(exp_coll));
   endtask

   task automatic run_until_n(input int target, input int budget);
      int k = 0;
      while (n != target && k < budget) begin
         step(1'b1);
         k++;
      end
      check("reach_n", n, target);
   endtask

   task automatic run_until_done(input int budget);
      int d0 = dones;
      int k = 0;
      while (dones == d0 && k < budget) begin
         step(1'b1);
         k++;
      end
      check("done_seen", dones, d0 + 1);
   endtask

   task automatic rand_others();
      for (int i = 1; i < N; i++) begin
         if (i == 2 || i == 3) continue;
         s_v[i]  = 1'($urandom_range(0, 1));
         s_x[i]  = 8'($urandom_range(100, 150));
         s_y[i]  = 7'($urandom_range(80, 110));
         s_sh[i] = 3'($urandom_range(0, 7));
         s_c[i]  = 3'($urandom_range(0, 7));
      end
      s_v[6] = 1'b1; s_x[6] = 8'd159; s_y[6] = 7'($urandom_range(40, 50));
      s_v[7] = 1'b1; s_x[7] = 8'd0;   s_y[7] = 7'($urandom_range(70, 110));
   endtask

   initial begin
      logic [7:0] gx;
      logic [6:0] gy;
      logic [7:0] dummy;
      int d_before;
      for (int i = 0; i < N; i++) begin
         s_v[i] = 1'b0; s_x[i] = '0; s_y[i] = '0; s_sh[i] = '0; s_c[i] = '0;
      end

      repeat (3) @(posedge clock);
      #1;
      check("rst_x", 32'(x), 0);
      check("rst_y", 32'(y), 0);
      check("rst_colour", 32'(colour), 0);
      check("rst_plot", 32'(plot), 0);
      check("rst_done", 32'(frame_done), 0);
      check("rst_coll", 32'(coll), 0);
      resetn = 1'b1;

      // Frame 1: no sprites; first plot two cycles after release
      step(1'b1);
      check("first_plot_early", 32'(plot), 0);
      step(1'b1);
      check("first_plot", 32'(plot), 1);
      check("first_xy", 32'({x, y}), 0);

      run_until_n(19000, 20000);
      s_v[0] = 1'b1; s_x[0] = 8'd80; s_y[0] = 7'd60; s_sh[0] = 3'd0; s_c[0] = 3'd7;
      s_v[2] = 1'b1; s_x[2] = 8'd0;  s_y[2] = 7'd0;  s_sh[2] = 3'd4; s_c[2] = 3'd5;
      s_v[3] = 1'b1; s_x[3] = 8'd82; s_y[3] = 7'd61; s_sh[3] = 3'd5; s_c[3] = 3'd5;
      rand_others();
      run_until_done(1000);

      // Frame 2: ship moves mid-frame, which must only show next frame
      run_until_n(40 * H, 8000);
      s_x[0] = 8'd90;
      rand_others();
      run_until_done(20000);
      check("interval_f2", done_cyc[1] - done_cyc[0], PIX);
      check("f2_80_59", 32'(fb_last[59][80]), 7);
      check("f2_79_60", 32'(fb_last[60][79]), 7);
      check("f2_81_60", 32'(fb_last[60][81]), 7);
      check("f2_79_61", 32'(fb_last[61][79]), 7);
      check("f2_81_61_overlap", 32'(fb_last[61][81]), 7);
      check("f2_79_59", 32'(fb_last[59][79]), 0);
      check("f2_80_61", 32'(fb_last[61][80]), 0);
      check("f2_83_61", 32'(fb_last[61][83]), 5);
      check("f2_0_0", 32'(fb_last[0][0]), 5);
      check("f2_159_119", 32'(fb_last[119][159]), 0);
      check("f2_159_0", 32'(fb_last[0][159]), 0);
      check("f2_0_119", 32'(fb_last[119][0]), 0);
      check("f2_coll", 32'(coll), 32'h09);

      // Frame 3: enable gap mid-line
      run_until_n(80 * H + 37, 20000);
      gx = '0;
      gy = '0;
      for (int i = 0; i < 100; i++) begin
         step(1'b0);
         if (i == 1) begin
            gx = x;
            gy = y;
         end
         if (i >= 2) begin
            check("gap_plot", 32'(plot), 0);
            check("gap_xy", 32'({x, y}), 32'({gx, gy}));
         end
      end
      run_until_done(20000);
      check("interval_f3", done_cyc[2] - done_cyc[1], PIX + 100);
      check("f3_90_59", 32'(fb_last[59][90]), 7);
      check("f3_80_59", 32'(fb_last[59][80]), 0);
      check("f3_89_61", 32'(fb_last[61][89]), 7);
      check("f3_coll", 32'(coll), 0);

      // Frame 4: aborted by reset
      s_v[0] = 1'b1; s_x[0] = 8'd81; s_y[0] = 7'd61; s_sh[0] = 3'd5;
      for (int i = 0; i < 5000; i++) step(1'b1);
      d_before = dones;
      resetn = 1'b0;
      #1;
      check("mid_rst_x", 32'(x), 0);
      check("mid_rst_y", 32'(y), 0);
      check("mid_rst_colour", 32'(colour), 0);
      check("mid_rst_plot", 32'(plot), 0);
      check("mid_rst_done", 32'(frame_done), 0);
      check("mid_rst_coll", 32'(coll), 0);
      n = 0;
      done_pend = 1'b0;
      exp_coll = '0;
      step(1'b1);
      step(1'b1);
      #3;
      resetn = 1'b1;
      step(1'b1);
      check("restart_plot_early", 32'(plot), 0);
      step(1'b1);
      check("restart_plot", 32'(plot), 1);
      check("restart_xy", 32'({x, y}), 0);
      run_until_n(3 * H, 1000);
      compare_frame(3 * H, dummy);
      check("no_done_after_abort", dones, d_before);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
